// File: rtl/riscv_pkg.sv
// =============================================================================
// riscv_pkg : shared constants for the multi-cycle RISC-V datapath
// Rev 1.0   : initial release
// =============================================================================
`default_nettype none

package riscv_pkg;

   localparam logic [1:0]  RESULT_SRC_ALUOUT = 2'b00;
   localparam logic [1:0]  RESULT_SRC_DATA   = 2'b01;
   localparam logic [1:0]  RESULT_SRC_ALURES = 2'b10;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   // Opcode field position within an instruction word
   localparam int OP_FIELD_MSB = 6;
   localparam int OP_FIELD_LSB = 0;
   localparam int OP_FIELD_W   = OP_FIELD_MSB - OP_FIELD_LSB + 1;

endpackage

`default_nettype wire

// File: rtl/en_reg.sv
// =============================================================================
// en_reg : enabled register with synchronous active-low reset
// Rev 1.0: initial release
// =============================================================================
`default_nettype none

module en_reg #(
   parameter int           W         = 32,
   parameter logic [W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] val_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_q <= RESET_VAL;
      end else if (en_i) begin
         val_q <= d_i;
      end
   end

   assign q_o = val_q;

endmodule

`default_nettype wire

// File: rtl/mc_datapath_regs.sv
// =============================================================================
// mc_datapath_regs : PC/OldPC/IR/MDR/A/B/ALUOut state plus Result and address muxes
// Rev 1.0          : initial release
// =============================================================================
`default_nettype none

module mc_datapath_regs
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pc_update,
   input  logic                  branch,
   input  logic                  zero,
   input  logic                  ir_write,
   input  logic                  adr_src,
   input  logic [1:0]            result_src,
   input  logic [XLEN-1:0]       read_data,
   input  logic [XLEN-1:0]       rd1,
   input  logic [XLEN-1:0]       rd2,
   input  logic [XLEN-1:0]       alu_result,
   output logic [XLEN-1:0]       pc,
   output logic [XLEN-1:0]       old_pc,
   output logic [XLEN-1:0]       instr,
   output logic [OP_FIELD_W-1:0] op,
   output logic [XLEN-1:0]       data,
   output logic [XLEN-1:0]       a,
   output logic [XLEN-1:0]       write_data,
   output logic [XLEN-1:0]       alu_out,
   output logic [XLEN-1:0]       result,
   output logic [XLEN-1:0]       adr
);

   localparam logic [XLEN-1:0] INSTR_RESET = XLEN'(INSTR_NOP);

   logic            pc_write;
   logic [XLEN-1:0] result_d;

   assign pc_write = pc_update | (branch & zero);

   en_reg #(.W(XLEN), .RESET_VAL(RESET_PC)) u_pc (
      .clk(clk), .rst_n(rst_n), .en_i(pc_write), .d_i(result_d), .q_o(pc)
   );

   // OldPC samples the pre-edge PC, so a simultaneous PC write during Fetch is safe
   en_reg #(.W(XLEN), .RESET_VAL(RESET_PC)) u_old_pc (
      .clk(clk), .rst_n(rst_n), .en_i(ir_write), .d_i(pc), .q_o(old_pc)
   );

   en_reg #(.W(XLEN), .RESET_VAL(INSTR_RESET)) u_instr (
      .clk(clk), .rst_n(rst_n), .en_i(ir_write), .d_i(read_data), .q_o(instr)
   );

   en_reg #(.W(XLEN), .RESET_VAL('0)) u_data (
      .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(read_data), .q_o(data)
   );

   en_reg #(.W(XLEN), .RESET_VAL('0)) u_a (
      .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(rd1), .q_o(a)
   );

   en_reg #(.W(XLEN), .RESET_VAL('0)) u_write_data (
      .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(rd2), .q_o(write_data)
   );

   en_reg #(.W(XLEN), .RESET_VAL('0)) u_alu_out (
      .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(alu_result), .q_o(alu_out)
   );

   always_comb begin
      result_d = '0;
      case (result_src)
         RESULT_SRC_ALUOUT: result_d = alu_out;
         RESULT_SRC_DATA:   result_d = data;
         RESULT_SRC_ALURES: result_d = alu_result;
         default:           result_d = '0;
      endcase
   end

   assign result = result_d;
   assign adr    = adr_src ? result_d : pc;
   assign op     = instr[OP_FIELD_MSB:OP_FIELD_LSB];

endmodule

`default_nettype wire

// File: tb/tb_mc_datapath_regs.sv
// =============================================================================
// tb_mc_datapath_regs : directed scoreboard bench for mc_datapath_regs
// Rev 1.0             : initial release
// =============================================================================
`default_nettype none

module tb_mc_datapath_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_update, branch, zero, ir_write, adr_src;
   logic [1:0]  result_src;
   logic [31:0] read_data, rd1, rd2, alu_result;
   logic [31:0] pc, old_pc, instr, data, a, write_data, alu_out, result, adr;
   logic [6:0]  op;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   mc_datapath_regs #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .pc_update(pc_update), .branch(branch),
      .zero(zero), .ir_write(ir_write), .adr_src(adr_src),
      .result_src(result_src), .read_data(read_data), .rd1(rd1), .rd2(rd2),
      .alu_result(alu_result), .pc(pc), .old_pc(old_pc), .instr(instr),
      .op(op), .data(data), .a(a), .write_data(write_data),
      .alu_out(alu_out), .result(result), .adr(adr)
   );

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $error("FAIL sb_underflow observed=%h expected=<queued value>", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; pc_update = 1'b0; branch = 1'b0; zero = 1'b0;
      ir_write = 1'b0; adr_src = 1'b0; result_src = 2'b00;
      read_data = '0; rd1 = '0; rd2 = '0; alu_result = '0;

      // Reset held for two edges
      step(); step();
      expect_val("rst_pc", 32'h0);          check(pc);
      expect_val("rst_old_pc", 32'h0);      check(old_pc);
      expect_val("rst_instr", 32'h13);      check(instr);
      expect_val("rst_op", 32'h13);         check({25'b0, op});
      expect_val("rst_data", 32'h0);        check(data);
      expect_val("rst_a", 32'h0);           check(a);
      expect_val("rst_wd", 32'h0);          check(write_data);
      expect_val("rst_alu_out", 32'h0);     check(alu_out);

      // Bring PC to 0x40
      rst_n = 1'b1; pc_update = 1'b1; result_src = 2'b10; alu_result = 32'h40;
      step();
      expect_val("pc_init", 32'h40);        check(pc);

      // Fetch: IR load and PC write on the same edge
      read_data = 32'h00A0_0093; ir_write = 1'b1; alu_result = 32'h44;
      #1;
      expect_val("fetch_adr", 32'h40);      check(adr);
      expect_val("fetch_result", 32'h44);   check(result);
      step();
      expect_val("fetch_instr", 32'h00A0_0093); check(instr);
      expect_val("fetch_op", 32'h13);       check({25'b0, op});
      expect_val("fetch_old_pc", 32'h40);   check(old_pc);
      expect_val("fetch_pc", 32'h44);       check(pc);

      // Branch not taken, taken, then forced by pc_update
      ir_write = 1'b0; pc_update = 1'b0; branch = 1'b1; zero = 1'b0;
      alu_result = 32'h80;
      step();
      expect_val("br_nt_pc", 32'h44);       check(pc);
      zero = 1'b1;
      step();
      expect_val("br_t_pc", 32'h80);        check(pc);
      expect_val("old_pc_hold", 32'h40);    check(old_pc);
      zero = 1'b0; pc_update = 1'b1; alu_result = 32'h90;
      step();
      expect_val("br_upd_pc", 32'h90);      check(pc);

      // Load alu_out/data/a/write_data, then sweep the Result mux
      branch = 1'b0; pc_update = 1'b0;
      alu_result = 32'h11; read_data = 32'h22; rd1 = 32'hA5; rd2 = 32'h5A;
      step();
      expect_val("a_load", 32'hA5);         check(a);
      expect_val("wd_load", 32'h5A);        check(write_data);
      alu_result = 32'h33;
      result_src = 2'b00; #1; expect_val("mux_00", 32'h11); check(result);
      result_src = 2'b01; #1; expect_val("mux_01", 32'h22); check(result);
      result_src = 2'b10; #1; expect_val("mux_10", 32'h33); check(result);
      result_src = 2'b11; #1; expect_val("mux_11", 32'h0);  check(result);
      result_src = 2'b00; adr_src = 1'b1;
      #1; expect_val("adr_result", 32'h11); check(adr);
      adr_src = 1'b0;
      #1; expect_val("adr_pc", 32'h90);     check(adr);

      // Load path without IR write
      read_data = 32'hDEAD_BEEF;
      step();
      expect_val("load_data", 32'hDEAD_BEEF);   check(data);
      expect_val("load_instr", 32'h00A0_0093);  check(instr);

      // PC wraps as written by the ALU
      pc_update = 1'b1; result_src = 2'b10; alu_result = 32'hFFFF_FFFC;
      step();
      expect_val("pc_top", 32'hFFFF_FFFC); check(pc);
      alu_result = 32'h0;
      step();
      expect_val("pc_wrap", 32'h0);         check(pc);

      // Reset coinciding with IR load and PC write
      alu_result = 32'h100; read_data = 32'h1234_5678;
      step();
      rst_n = 1'b0; ir_write = 1'b1; pc_update = 1'b1;
      alu_result = 32'h200; read_data = 32'h8765_4321; rd1 = 32'h7; rd2 = 32'h9;
      step();
      expect_val("mrst_pc", 32'h0);         check(pc);
      expect_val("mrst_old_pc", 32'h0);     check(old_pc);
      expect_val("mrst_instr", 32'h13);     check(instr);
      expect_val("mrst_data", 32'h0);       check(data);
      expect_val("mrst_a", 32'h0);          check(a);
      expect_val("mrst_wd", 32'h0);         check(write_data);
      expect_val("mrst_alu_out", 32'h0);    check(alu_out);

      checks++;
      assert (sbq.size() == 0) else begin
         errors++;
         $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mc_datapath_regs.md
# mc_datapath_regs

Architectural and non-architectural state registers of the multi-cycle RISC-V datapath, directly downstream of `main_fsm`. The block consumes the FSM control strobes `pc_update`, `branch`, `ir_write`, `adr_src` and `result_src`. It holds PC, OldPC, IR, the memory data register, A/B and ALUOut. It drives the memory address, the Result bus, and the `op` field that feeds back into `main_fsm`.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.

Ports (reset is synchronous and active-low; one clock):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `pc_update`  in  1  unconditional PC write (FSM).
- `branch`  in  1  conditional PC write (FSM).
- `zero`  in  1  ALU zero flag.
- `ir_write`  in  1  load IR and OldPC (FSM).
- `adr_src`  in  1  memory address select: 0 selects PC, 1 selects Result.
- `result_src`  in  2  Result mux select (FSM).
- `read_data`  in  XLEN  memory read data.
- `rd1`, `rd2`  in  XLEN  register-file read ports.
- `alu_result`  in  XLEN  combinational ALU output.
- `pc`, `old_pc`  out  XLEN  registered.
- `instr`  out  XLEN  registered IR.
- `op`  out  7  `instr[6:0]`, to `main_fsm`.
- `data`  out  XLEN  registered memory data.
- `a`  out  XLEN  registered `rd1`.
- `write_data`  out  XLEN  registered `rd2`; this is the store data.
- `alu_out`  out  XLEN  registered `alu_result`.
- `result`  out  XLEN  combinational Result bus.
- `adr`  out  XLEN  combinational memory address.

## Operation
- `pc_write = pc_update | (branch & zero)`. When `pc_write` is high, `pc <= result`. Otherwise PC holds.
- When `ir_write` is high, `instr <= read_data` and `old_pc <= pc`. `old_pc` captures the pre-update PC even when `pc_write` is asserted in the same cycle, which is the normal Fetch case.
- `data`, `a`, `write_data` and `alu_out` load unconditionally every cycle.
- Result mux:
  - 00 selects `alu_out`.
  - 01 selects `data`.
  - 10 selects `alu_result`.
  - 11 is reserved and drives 0.
- `adr = adr_src ? result : pc`.
- `op` is a pure slice of `instr`. No decode happens in this block.
- PC is stored as written. Alignment checking is not performed here.

## Timing
- Reset values, applied when `rst_n` is low at a rising edge:
  - `pc = RESET_PC`
  - `old_pc = RESET_PC`
  - `instr = 32'h0000_0013` (NOP; `op = 7'b0010011`)
  - `data`, `a`, `write_data`, `alu_out` = 0
- Reset dominates every enable.
- Reset asserted mid-instruction discards all in-flight state on that edge. No partial update survives.
- Latency: every registered output reflects its input one cycle after the enabling edge. `result` and `adr` are combinational from current state and inputs, with zero cycles of latency.
- `branch` high with `zero` low leaves PC unchanged. `pc_update` and `branch` both high writes PC regardless of `zero`.
- `ir_write` and `pc_write` in the same cycle: both update on that edge, using values sampled before the edge.
- `pc` wrap-around: `RESET_PC` plus increments beyond 2^XLEN-1 wrap modulo 2^XLEN. The ALU is responsible for the wrap; this block applies no saturation.
- No combinational path from `rst_n` to any output.

## Structure
- Shared package `riscv_pkg`:
  - `RESULT_SRC_ALUOUT=2'b00`
  - `RESULT_SRC_DATA=2'b01`
  - `RESULT_SRC_ALURES=2'b10`
  - `INSTR_NOP=32'h0000_0013`
  - `OP_FIELD` range constants
- Sub-module `en_reg`: parameterised width, reset value and enable. Synchronous active-low reset. Instantiated for each of the 7 state registers, with enable tied high where the load is unconditional.
- The Result and address muxes are inline combinational logic in the top.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `RESET_PC`=0 -> `pc`=0, `old_pc`=0, `instr`=32'h0000_0013, `op`=7'b0010011, all other registers 0.
- Fetch: `pc`=0x40, `read_data`=0x00A00093, `ir_write`=1, `pc_update`=1, `result_src`=10, `alu_result`=0x44 -> next cycle `instr`=0x00A00093, `op`=7'b0010011, `old_pc`=0x40, `pc`=0x44.
- Branch: `branch`=1, `zero`=0, `result`=0x80 -> `pc` unchanged. Repeat with `zero`=1 -> `pc`=0x80.
- Muxes: `alu_out`=0x11, `data`=0x22, `alu_result`=0x33; step `result_src` through 00/01/10/11 -> `result`=0x11/0x22/0x33/0. `adr_src`=1 -> `adr`=`result`; `adr_src`=0 -> `adr`=`pc`.
- Load path: `read_data`=0xDEADBEEF with `ir_write`=0 -> next cycle `data`=0xDEADBEEF and `instr` unchanged.
- Mid-operation reset: `rst_n`=0 in the same cycle as `ir_write`=1 and `pc_update`=1 -> reset values only, no capture.
